// File: rtl/strip_placement_engine.sv
// strip_placement_engine
//
// Sequential strip allocator for multi-program placement. Keeps the occupied
// width of NUM_STRIPS strips and serves one program request at a time: scans
// all strips for the least-occupied one (lowest index wins ties), adds the
// requested width and reports a strike when the result would exceed STRIP_LEN.
// Requests that fit are committed to the chosen strip; strikes leave every
// strip untouched.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   clear           synchronous: empty all strips, drop any request in flight
//   in_valid/ready  request handshake; width_in is latched on acceptance
//   out_valid/ready result handshake; result held stable until consumed
//   out_strike      1 = request does not fit, strips unchanged
//   out_strip_idx   chosen (least-occupied) strip
//   out_offset      occupancy of that strip before the request
//   out_new_width   out_offset + width, full precision
//   busy            engine is not idle
//   strike_count    (STRIKE_COUNTER_EN only) saturating count of strikes
//
// Configuration macro: STRIKE_COUNTER_EN adds the strike_count output and its
// counter. Without it the port and logic are absent; all else is identical.

module strip_placement_engine #(
  parameter int NUM_STRIPS = 4,
  parameter int STRIP_LEN  = 128,
  parameter int WIDTH_W    = 5,
  localparam int IDX_W     = $clog2(NUM_STRIPS),
  localparam int OCC_W     = $clog2(STRIP_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_W-1:0] width_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_strike,
  output logic [IDX_W-1:0]   out_strip_idx,
  output logic [OCC_W-1:0]   out_offset,
  output logic [OCC_W:0]     out_new_width,
  output logic               busy
`ifdef STRIKE_COUNTER_EN
  ,
  output logic [15:0]        strike_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DECIDE,
    S_RESP
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STRIPS - 1);
  localparam logic [OCC_W:0]   LIMIT    = (OCC_W + 1)'(STRIP_LEN);

  state_t               state;
  state_t               state_next;
  logic [OCC_W-1:0]     strips [NUM_STRIPS];
  logic [IDX_W-1:0]     scan_idx;
  logic [IDX_W-1:0]     min_idx;
  logic [OCC_W-1:0]     min_val;
  logic [WIDTH_W-1:0]   width_r;
  logic [OCC_W:0]       sum;
  logic                 strike;
  logic                 accept;

  // One extra bit on the sum so an overflowing placement is reported exactly
  // rather than wrapping back into range.
  assign sum    = {1'b0, min_val} + (OCC_W + 1)'(width_r);
  assign strike = (sum > LIMIT);
  assign accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs. clear overrides every transition and
  // also blocks acceptance in the cycle it is asserted.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != S_IDLE);
    if (state == S_IDLE) begin
      in_ready = !clear;
    end
    if (state == S_RESP) begin
      out_valid = 1'b1;
    end
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (accept) state_next = S_SCAN;
        S_SCAN:   if (scan_idx == LAST_IDX) state_next = S_DECIDE;
        S_DECIDE: state_next = S_RESP;
        S_RESP:   if (out_ready) state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: strip occupancy, running-minimum scan and result registers.
  // The first scanned strip always seeds the minimum; later strips replace it
  // only when strictly smaller so ties resolve to the lowest index. A clear in
  // the same cycle as DECIDE wins, which discards that commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STRIPS; i++) strips[i] <= '0;
      scan_idx      <= '0;
      min_idx       <= '0;
      min_val       <= '0;
      width_r       <= '0;
      out_strike    <= 1'b0;
      out_strip_idx <= '0;
      out_offset    <= '0;
      out_new_width <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_STRIPS; i++) strips[i] <= '0;
      scan_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            width_r  <= width_in;
            scan_idx <= '0;
          end
        end
        S_SCAN: begin
          if ((scan_idx == '0) || (strips[scan_idx] < min_val)) begin
            min_val <= strips[scan_idx];
            min_idx <= scan_idx;
          end
          scan_idx <= scan_idx + IDX_W'(1);
        end
        S_DECIDE: begin
          out_strike    <= strike;
          out_strip_idx <= min_idx;
          out_offset    <= min_val;
          out_new_width <= sum;
          if (!strike) begin
            strips[min_idx] <= sum[OCC_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STRIKE_COUNTER_EN
  // Saturating strike counter, advanced once per striking decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strike_count <= '0;
    end else if (clear) begin
      strike_count <= '0;
    end else if ((state == S_DECIDE) && strike && (strike_count != 16'hFFFF)) begin
      strike_count <= strike_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_strip_placement_engine.sv
// Self-checking bench for strip_placement_engine: directed scenarios plus
// randomized requests, all compared against a behavioural occupancy model.

module tb_strip_placement_engine;

  localparam int NUM_STRIPS = 4;
  localparam int STRIP_LEN  = 128;
  localparam int WIDTH_W    = 5;
  localparam int IDX_W      = 2;
  localparam int OCC_W      = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH_W-1:0] width_in;
  logic               out_valid;
  logic               out_ready;
  logic               out_strike;
  logic [IDX_W-1:0]   out_strip_idx;
  logic [OCC_W-1:0]   out_offset;
  logic [OCC_W:0]     out_new_width;
  logic               busy;
`ifdef STRIKE_COUNTER_EN
  logic [15:0]        strike_count;
`endif

  int checks = 0;
  int errors = 0;
  int model_strips [NUM_STRIPS];

  always #5 clk = ~clk;

  strip_placement_engine #(
    .NUM_STRIPS(NUM_STRIPS),
    .STRIP_LEN (STRIP_LEN),
    .WIDTH_W   (WIDTH_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .width_in     (width_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_strike   (out_strike),
    .out_strip_idx(out_strip_idx),
    .out_offset   (out_offset),
    .out_new_width(out_new_width),
    .busy         (busy)
`ifdef STRIKE_COUNTER_EN
    ,
    .strike_count (strike_count)
`endif
  );

  // Reference model: strips as plain integers, least-occupied lowest-index pick.
  function automatic void model_clear();
    for (int i = 0; i < NUM_STRIPS; i++) model_strips[i] = 0;
  endfunction

  function automatic void model_place(input int w, output int idx, output int off,
                                      output int nw, output int strike);
    idx = 0;
    for (int i = 1; i < NUM_STRIPS; i++)
      if (model_strips[i] < model_strips[idx]) idx = i;
    off    = model_strips[idx];
    nw     = off + w;
    strike = (nw > STRIP_LEN) ? 1 : 0;
    if (strike == 0) model_strips[idx] = nw;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    model_clear();
  endtask

  // Issues one request from IDLE, waits (bounded) for the result, holds
  // out_ready low for 'hold' cycles, then completes the handshake.
  task automatic do_request(input int w, input int hold,
                            output logic [31:0] o_strike, output logic [31:0] o_idx,
                            output logic [31:0] o_off, output logic [31:0] o_new,
                            output int lat, output bit timeout);
    timeout  = 1'b0;
    lat      = 0;
    in_valid = 1'b1;
    width_in = WIDTH_W'(w);
    @(posedge clk); #1;
    in_valid = 1'b0;
    width_in = WIDTH_W'($urandom);
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) timeout = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    o_strike = 32'(out_strike);
    o_idx    = 32'(out_strip_idx);
    o_off    = 32'(out_offset);
    o_new    = 32'(out_new_width);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy, out_strike, out_strip_idx, out_offset, out_new_width}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 9'd0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got in_ready=%b out_valid=%b busy=%b strike=%b idx=%0d off=%0d new=%0d, expected 1 0 0 0 0 0 0",
               in_ready, out_valid, busy, out_strike, out_strip_idx, out_offset, out_new_width);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    model_clear();
  endtask

  task automatic test_single();
    logic [31:0] s, i, o, n;
    int lat, es, ei, eo, en;
    bit to;
    do_reset();
    model_place(10, ei, eo, en, es);
    do_request(10, 0, s, i, o, n, lat, to);
    checks++;
    if (to || s !== 0 || i !== 0 || o !== 0 || n !== 10 || s !== es || n !== en) begin
      errors++;
      $display("[TB] FAIL single: got strike=%0d idx=%0d off=%0d new=%0d timeout=%0d, expected 0 0 0 10",
               s, i, o, n, to);
    end
    checks++;
    if (lat !== NUM_STRIPS + 1) begin
      errors++;
      $display("[TB] FAIL latency: got %0d cycles, expected %0d", lat, NUM_STRIPS + 1);
    end
  endtask

  task automatic test_sequence();
    int ws [5] = '{10, 20, 5, 7, 3};
    logic [31:0] s, i, o, n;
    int lat, es, ei, eo, en;
    bit to;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      model_place(ws[k], ei, eo, en, es);
      do_request(ws[k], 0, s, i, o, n, lat, to);
      checks++;
      if (to || s !== es || i !== ei || o !== eo || n !== en) begin
        errors++;
        $display("[TB] FAIL sequence[%0d]: got strike=%0d idx=%0d off=%0d new=%0d timeout=%0d, expected %0d %0d %0d %0d",
                 k, s, i, o, n, to, es, ei, eo, en);
      end
    end
    checks++;
    if (i !== 2 || o !== 5 || n !== 8) begin
      errors++;
      $display("[TB] FAIL sequence_tie: got idx=%0d off=%0d new=%0d, expected 2 5 8", i, o, n);
    end
  endtask

  task automatic test_fill_strike();
    logic [31:0] s, i, o, n;
    int lat, es, ei, eo, en, w;
    bit to;
    do_reset();
    for (int k = 0; k < 19; k++) begin
      w = (k < 16) ? 30 : ((k == 16) ? 8 : 9);
      model_place(w, ei, eo, en, es);
      do_request(w, 0, s, i, o, n, lat, to);
      checks++;
      if (to || s !== es || i !== ei || o !== eo || n !== en) begin
        errors++;
        $display("[TB] FAIL fill[%0d]: got strike=%0d idx=%0d off=%0d new=%0d timeout=%0d, expected %0d %0d %0d %0d",
                 k, s, i, o, n, to, es, ei, eo, en);
      end
    end
    checks++;
    if (s !== 1 || i !== 1 || o !== 120 || n !== 129) begin
      errors++;
      $display("[TB] FAIL strike_boundary: got strike=%0d idx=%0d off=%0d new=%0d, expected 1 1 120 129", s, i, o, n);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] cap;
    int es, ei, eo, en, w, lat;
    bit stable;
    do_reset();
    w = $urandom_range(1, 31);
    model_place(w, ei, eo, en, es);
    in_valid = 1'b1;
    width_in = WIDTH_W'(w);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    cap = {19'd0, out_strike, out_strip_idx, out_offset, out_new_width};
    checks++;
    if (out_valid !== 1'b1 || cap !== {19'd0, 1'(es), 2'(ei), 8'(eo), 9'(en)}) begin
      errors++;
      $display("[TB] FAIL bp_result: got valid=%b packed=%h, expected valid=1 packed=%h",
               out_valid, cap, {19'd0, 1'(es), 2'(ei), 8'(eo), 9'(en)});
    end
    in_valid = 1'b1;
    width_in = WIDTH_W'($urandom);
    stable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {19'd0, out_strike, out_strip_idx, out_offset, out_new_width} !== cap) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("[TB] FAIL bp_hold: got valid=%b in_ready=%b packed=%h, expected 1 0 %h",
               out_valid, in_ready, {19'd0, out_strike, out_strip_idx, out_offset, out_new_width}, cap);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: got in_ready=%b busy=%b out_valid=%b, expected 1 0 0",
               in_ready, busy, out_valid);
    end
  endtask

  task automatic test_clear();
    logic [31:0] s, i, o, n;
    int lat, es, ei, eo, en;
    bit to, rose;
    for (int use_rst = 0; use_rst < 2; use_rst++) begin
      for (int d = 0; d < 5; d++) begin
        do_reset();
        model_place(7, ei, eo, en, es);
        do_request(7, 0, s, i, o, n, lat, to);
        model_place(9, ei, eo, en, es);
        do_request(9, 0, s, i, o, n, lat, to);
        in_valid = 1'b1;
        width_in = 5'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (d) begin
          @(posedge clk); #1;
        end
        if (use_rst == 1) begin
          rst = 1'b1;
          #1;
          rst = 1'b0;
        end else begin
          clear = 1'b1;
          @(posedge clk); #1;
          clear = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL abort[rst=%0d,d=%0d]: got out_valid=%b busy=%b, expected 0 0",
                   use_rst, d, out_valid, busy);
        end
        rose = 1'b0;
        for (int k = 0; k < 6; k++) begin
          @(posedge clk); #1;
          if (out_valid !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose) begin
          errors++;
          $display("[TB] FAIL abort_no_result[rst=%0d,d=%0d]: got out_valid=1, expected 0", use_rst, d);
        end
        model_clear();
        for (int k = 0; k < NUM_STRIPS; k++) begin
          model_place(4, ei, eo, en, es);
          do_request(4, 0, s, i, o, n, lat, to);
          checks++;
          if (to || s !== es || i !== ei || o !== eo || n !== en) begin
            errors++;
            $display("[TB] FAIL after_abort[rst=%0d,d=%0d,%0d]: got strike=%0d idx=%0d off=%0d new=%0d timeout=%0d, expected %0d %0d %0d %0d",
                     use_rst, d, k, s, i, o, n, to, es, ei, eo, en);
          end
        end
      end
    end
    clear    = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_blocks_ready: got in_ready=%b, expected 0", in_ready);
    end
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_no_accept: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_random();
    logic [31:0] s, i, o, n;
    int lat, es, ei, eo, en, w;
    bit to;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
      model_place(w, ei, eo, en, es);
      do_request(w, $urandom_range(0, 3), s, i, o, n, lat, to);
      checks++;
      if (to || lat !== NUM_STRIPS + 1 || s !== es || i !== ei || o !== eo || n !== en) begin
        errors++;
        $display("[TB] FAIL random[%0d] w=%0d: got strike=%0d idx=%0d off=%0d new=%0d lat=%0d, expected %0d %0d %0d %0d lat=%0d",
                 k, w, s, i, o, n, lat, es, ei, eo, en, NUM_STRIPS + 1);
      end
    end
  endtask

`ifdef STRIKE_COUNTER_EN
  task automatic test_strike_counter();
    logic [31:0] s, i, o, n;
    int lat, es, ei, eo, en, w;
    bit to;
    do_reset();
    for (int k = 0; k < 19; k++) begin
      w = (k < 16) ? 30 : 9;
      model_place(w, ei, eo, en, es);
      do_request(w, 0, s, i, o, n, lat, to);
    end
    checks++;
    if (strike_count !== 16'd3) begin
      errors++;
      $display("[TB] FAIL strike_count: got %0d, expected 3", strike_count);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (strike_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL strike_count_clear: got %0d, expected 0", strike_count);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    width_in  = '0;
    test_reset();
    test_single();
    test_sequence();
    test_fill_strike();
    test_backpressure();
    test_clear();
    test_random();
`ifdef STRIKE_COUNTER_EN
    test_strike_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
